// File: rtl/demux_ctrl.sv
// Receive-side PCIe framing demultiplexer: strips IDL/SKP, frames STP/SDP..END
// packets into a sop/eop byte stream and flags malformed framing on err_out.
module demux_ctrl #(
  parameter int MAX_LEN = 1024
) (
  input  logic       clk,
  input  logic       reset_L,
  input  logic       enb,
  input  logic       valid_in,
  input  logic [7:0] data_in,
  input  logic       k_in,
  output logic [7:0] data_out,
  output logic       valid_out,
  output logic       sop_out,
  output logic       eop_out,
  output logic       type_out,
  output logic       err_out
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StTlp  = 2'd1;
  localparam logic [1:0] StDllp = 2'd2;

  localparam logic [7:0] SymStp = 8'hFB;
  localparam logic [7:0] SymSdp = 8'h5C;
  localparam logic [7:0] SymEnd = 8'hFD;
  localparam logic [7:0] SymIdl = 8'h7C;
  localparam logic [7:0] SymSkp = 8'h1C;

  localparam logic [11:0] MaxCount = 12'(MAX_LEN);

  logic [1:0]  state_q, state_d;
  logic [11:0] count_q, count_d;
  logic [7:0]  pendData_q, pendData_d;
  logic        pendValid_q, pendValid_d;
  logic        sentFirst_q, sentFirst_d;
  logic        type_q, type_d;
  logic [7:0]  dataOut_q, dataOut_d;
  logic        validOut_q, validOut_d;
  logic        sop_q, sop_d;
  logic        eop_q, eop_d;
  logic        err_q, err_d;
  logic        accept;

  assign accept = enb & valid_in;

  // Pulse outputs (valid/sop/eop/err) default low every cycle so a held
  // block never repeats a byte or an error; everything else holds.
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    pendData_d  = pendData_q;
    pendValid_d = pendValid_q;
    sentFirst_d = sentFirst_q;
    type_d      = type_q;
    dataOut_d   = dataOut_q;
    validOut_d  = 1'b0;
    sop_d       = 1'b0;
    eop_d       = 1'b0;
    err_d       = 1'b0;

    if (accept) begin
      if (state_q == StIdle) begin
        if (k_in && data_in == SymStp) begin
          state_d     = StTlp;
          type_d      = 1'b0;
          count_d     = 12'd0;
          pendValid_d = 1'b0;
          sentFirst_d = 1'b0;
        end else if (k_in && data_in == SymSdp) begin
          state_d     = StDllp;
          type_d      = 1'b1;
          count_d     = 12'd0;
          pendValid_d = 1'b0;
          sentFirst_d = 1'b0;
        end else if (!(k_in && (data_in == SymIdl || data_in == SymSkp))) begin
          err_d = 1'b1;
        end
      end else if (state_q == StTlp || state_q == StDllp) begin
        if (!k_in && count_q >= MaxCount) begin
          err_d       = 1'b1;
          state_d     = StIdle;
          pendValid_d = 1'b0;
        end else if (!k_in) begin
          count_d     = count_q + 12'd1;
          pendData_d  = data_in;
          pendValid_d = 1'b1;
          if (pendValid_q) begin
            dataOut_d   = pendData_q;
            validOut_d  = 1'b1;
            sop_d       = ~sentFirst_q;
            sentFirst_d = 1'b1;
          end
        end else if (data_in == SymSkp) begin
          state_d = state_q;
        end else if (data_in == SymEnd && count_q != 12'd0) begin
          // A non-zero count guarantees a pending byte to close with eop.
          dataOut_d   = pendData_q;
          validOut_d  = 1'b1;
          sop_d       = ~sentFirst_q;
          eop_d       = 1'b1;
          sentFirst_d = 1'b1;
          pendValid_d = 1'b0;
          state_d     = StIdle;
        end else begin
          err_d       = 1'b1;
          state_d     = StIdle;
          pendValid_d = 1'b0;
        end
      end else begin
        state_d = StIdle;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state_q     <= StIdle;
      count_q     <= 12'd0;
      pendData_q  <= 8'd0;
      pendValid_q <= 1'b0;
      sentFirst_q <= 1'b0;
      type_q      <= 1'b0;
      dataOut_q   <= 8'd0;
      validOut_q  <= 1'b0;
      sop_q       <= 1'b0;
      eop_q       <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      pendData_q  <= pendData_d;
      pendValid_q <= pendValid_d;
      sentFirst_q <= sentFirst_d;
      type_q      <= type_d;
      dataOut_q   <= dataOut_d;
      validOut_q  <= validOut_d;
      sop_q       <= sop_d;
      eop_q       <= eop_d;
      err_q       <= err_d;
    end
  end

  assign data_out  = dataOut_q;
  assign valid_out = validOut_q;
  assign sop_out   = sop_q;
  assign eop_out   = eop_q;
  assign type_out  = type_q;
  assign err_out   = err_q;

endmodule

// File: tb/tb_demux_ctrl.sv
// Directed bench for demux_ctrl: one symbol per step, outputs compared
// against hand-computed vectors {valid,sop,eop,type,err,data}.
module tb_demux_ctrl;

  logic       clk;
  logic       reset_L;
  logic       enb;
  logic       valid_in;
  logic [7:0] data_in;
  logic       k_in;

  logic [7:0] dataOut, dataOut4;
  logic       validOut, validOut4;
  logic       sopOut, sopOut4;
  logic       eopOut, eopOut4;
  logic       typeOut, typeOut4;
  logic       errOut, errOut4;

  int checkCount = 0;
  int passCount  = 0;

  localparam logic [7:0] STP = 8'hFB;
  localparam logic [7:0] SDP = 8'h5C;
  localparam logic [7:0] ENDS = 8'hFD;
  localparam logic [7:0] EDB = 8'hFE;
  localparam logic [7:0] IDL = 8'h7C;
  localparam logic [7:0] SKP = 8'h1C;

  demux_ctrl dut (
    .clk(clk), .reset_L(reset_L), .enb(enb), .valid_in(valid_in),
    .data_in(data_in), .k_in(k_in), .data_out(dataOut), .valid_out(validOut),
    .sop_out(sopOut), .eop_out(eopOut), .type_out(typeOut), .err_out(errOut)
  );

  demux_ctrl #(.MAX_LEN(4)) dut4 (
    .clk(clk), .reset_L(reset_L), .enb(enb), .valid_in(valid_in),
    .data_in(data_in), .k_in(k_in), .data_out(dataOut4), .valid_out(validOut4),
    .sop_out(sopOut4), .eop_out(eopOut4), .type_out(typeOut4), .err_out(errOut4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected-vector builder; data only matters when valid is set.
  function automatic logic [12:0] vec(input logic v, input logic s, input logic e,
                                      input logic t, input logic er, input logic [7:0] d);
    return {v, s, e, t, er, (v ? d : 8'h00)};
  endfunction

  function automatic logic [12:0] obsMain();
    return vec(validOut, sopOut, eopOut, typeOut, errOut, dataOut);
  endfunction

  function automatic logic [12:0] obsMax();
    return vec(validOut4, sopOut4, eopOut4, typeOut4, errOut4, dataOut4);
  endfunction

  task automatic checkOutput(input string tag, input logic [12:0] observed,
                             input logic [12:0] expected);
    checkCount++;
    if (observed === expected) passCount++;
    else $display("[TB] FAIL %s: got %h (v,s,e,t,err,data) expected %h", tag, observed, expected);
  endtask

  // Present one symbol at the falling edge and return just after the rising
  // edge that consumes it, so the outputs reflect that symbol.
  task automatic applyStimulus(input logic v, input logic k, input logic [7:0] d,
                               input logic en = 1'b1);
    @(negedge clk);
    valid_in = v;
    k_in     = k;
    data_in  = d;
    enb      = en;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_L  = 1'b0;
    enb      = 1'b0;
    valid_in = 1'b0;
    k_in     = 1'b0;
    data_in  = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset", {validOut, sopOut, eopOut, typeOut, errOut, dataOut}, 13'd0);
    @(negedge clk);
    reset_L = 1'b1;

    // Basic TLP with leading idles
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 1, IDL);
      checkOutput("idl", obsMain(), vec(0, 0, 0, 0, 0, 8'h00));
    end
    applyStimulus(1, 1, STP);  checkOutput("t1 stp", obsMain(), vec(0, 0, 0, 0, 0, 8'h00));
    applyStimulus(1, 0, 8'hAA); checkOutput("t1 aa", obsMain(), vec(0, 0, 0, 0, 0, 8'h00));
    applyStimulus(1, 0, 8'hBB); checkOutput("t1 bb", obsMain(), vec(1, 1, 0, 0, 0, 8'hAA));
    applyStimulus(1, 0, 8'hCC); checkOutput("t1 cc", obsMain(), vec(1, 0, 0, 0, 0, 8'hBB));
    applyStimulus(1, 1, ENDS);  checkOutput("t1 end", obsMain(), vec(1, 0, 1, 0, 0, 8'hCC));
    applyStimulus(0, 0, 8'h00); checkOutput("t1 gap", obsMain(), vec(0, 0, 0, 0, 0, 8'h00));

    // DLLP with SKP, then back-to-back 1-byte TLP
    applyStimulus(1, 1, SDP);   checkOutput("t2 sdp", obsMain(), vec(0, 0, 0, 1, 0, 8'h00));
    applyStimulus(1, 0, 8'h11); checkOutput("t2 11", obsMain(), vec(0, 0, 0, 1, 0, 8'h00));
    applyStimulus(1, 1, SKP);   checkOutput("t2 skp", obsMain(), vec(0, 0, 0, 1, 0, 8'h00));
    applyStimulus(1, 0, 8'h22); checkOutput("t2 22", obsMain(), vec(1, 1, 0, 1, 0, 8'h11));
    applyStimulus(1, 1, ENDS);  checkOutput("t2 end", obsMain(), vec(1, 0, 1, 1, 0, 8'h22));
    applyStimulus(1, 1, STP);   checkOutput("t2 stp", obsMain(), vec(0, 0, 0, 0, 0, 8'h00));
    applyStimulus(1, 0, 8'h33); checkOutput("t2 33", obsMain(), vec(0, 0, 0, 0, 0, 8'h00));
    applyStimulus(1, 1, ENDS);  checkOutput("t2 end1", obsMain(), vec(1, 1, 1, 0, 0, 8'h33));

    // EDB abort, then a clean DLLP
    applyStimulus(1, 1, STP);   checkOutput("t3 stp", obsMain(), vec(0, 0, 0, 0, 0, 8'h00));
    applyStimulus(1, 0, 8'h44); checkOutput("t3 44", obsMain(), vec(0, 0, 0, 0, 0, 8'h00));
    applyStimulus(1, 0, 8'h55); checkOutput("t3 55", obsMain(), vec(1, 1, 0, 0, 0, 8'h44));
    applyStimulus(1, 1, EDB);   checkOutput("t3 edb", obsMain(), vec(0, 0, 0, 0, 1, 8'h00));
    applyStimulus(1, 1, SDP);   checkOutput("t3 sdp", obsMain(), vec(0, 0, 0, 1, 0, 8'h00));
    applyStimulus(1, 0, 8'h66); checkOutput("t3 66", obsMain(), vec(0, 0, 0, 1, 0, 8'h00));
    applyStimulus(1, 1, ENDS);  checkOutput("t3 end", obsMain(), vec(1, 1, 1, 1, 0, 8'h66));

    // Errors in IDLE and an empty packet
    applyStimulus(1, 1, ENDS);  checkOutput("t4 end", obsMain(), vec(0, 0, 0, 1, 1, 8'h00));
    applyStimulus(0, 0, 8'h00); checkOutput("t4 pulse", obsMain(), vec(0, 0, 0, 1, 0, 8'h00));
    applyStimulus(1, 0, 8'h77); checkOutput("t4 data", obsMain(), vec(0, 0, 0, 1, 1, 8'h00));
    applyStimulus(1, 1, 8'hF7); checkOutput("t4 unk", obsMain(), vec(0, 0, 0, 1, 1, 8'h00));
    applyStimulus(1, 1, STP);   checkOutput("t4 stp", obsMain(), vec(0, 0, 0, 0, 0, 8'h00));
    applyStimulus(1, 1, ENDS);  checkOutput("t4 empty", obsMain(), vec(0, 0, 0, 0, 1, 8'h00));

    // MAX_LEN=4 overflow on the second instance
    applyStimulus(1, 1, STP);   checkOutput("t5 stp", obsMax(), vec(0, 0, 0, 0, 0, 8'h00));
    applyStimulus(1, 0, 8'h01); checkOutput("t5 b1", obsMax(), vec(0, 0, 0, 0, 0, 8'h00));
    applyStimulus(1, 0, 8'h02); checkOutput("t5 b2", obsMax(), vec(1, 1, 0, 0, 0, 8'h01));
    applyStimulus(1, 0, 8'h03); checkOutput("t5 b3", obsMax(), vec(1, 0, 0, 0, 0, 8'h02));
    applyStimulus(1, 0, 8'h04); checkOutput("t5 b4", obsMax(), vec(1, 0, 0, 0, 0, 8'h03));
    applyStimulus(1, 0, 8'h05); checkOutput("t5 b5", obsMax(), vec(0, 0, 0, 0, 1, 8'h00));
    checkOutput("t5 big ok", obsMain(), vec(1, 0, 0, 0, 0, 8'h04));
    applyStimulus(1, 1, ENDS);  checkOutput("t5 big end", obsMain(), vec(1, 0, 1, 0, 0, 8'h05));

    // enb=0 holds state even with a valid END presented
    applyStimulus(1, 1, SDP);        checkOutput("t6 sdp", obsMain(), vec(0, 0, 0, 1, 0, 8'h00));
    applyStimulus(1, 0, 8'h0A);      checkOutput("t6 0a", obsMain(), vec(0, 0, 0, 1, 0, 8'h00));
    applyStimulus(1, 1, ENDS, 1'b0); checkOutput("t6 hold1", obsMain(), vec(0, 0, 0, 1, 0, 8'h00));
    applyStimulus(1, 0, 8'h0B);      checkOutput("t6 0b", obsMain(), vec(1, 1, 0, 1, 0, 8'h0A));
    applyStimulus(1, 0, 8'h99, 1'b0); checkOutput("t6 hold2", obsMain(), vec(0, 0, 0, 1, 0, 8'h00));
    applyStimulus(1, 1, ENDS);       checkOutput("t6 end", obsMain(), vec(1, 0, 1, 1, 0, 8'h0B));

    // Asynchronous reset mid-packet
    applyStimulus(1, 1, STP);   checkOutput("t7 stp", obsMain(), vec(0, 0, 0, 0, 0, 8'h00));
    applyStimulus(1, 0, 8'h12); checkOutput("t7 12", obsMain(), vec(0, 0, 0, 0, 0, 8'h00));
    applyStimulus(1, 0, 8'h34); checkOutput("t7 34", obsMain(), vec(1, 1, 0, 0, 0, 8'h12));
    #2;
    reset_L = 1'b0;
    #1;
    checkOutput("t7 async", {validOut, sopOut, eopOut, typeOut, errOut, dataOut}, 13'd0);
    @(negedge clk);
    valid_in = 1'b0;
    @(negedge clk);
    reset_L = 1'b1;
    applyStimulus(1, 1, SDP);   checkOutput("t7 sdp", obsMain(), vec(0, 0, 0, 1, 0, 8'h00));
    applyStimulus(1, 0, 8'h56); checkOutput("t7 56", obsMain(), vec(0, 0, 0, 1, 0, 8'h00));
    applyStimulus(1, 1, ENDS);  checkOutput("t7 end", obsMain(), vec(1, 1, 1, 1, 0, 8'h56));
    applyStimulus(0, 0, 8'h00); checkOutput("t7 quiet", obsMain(), vec(0, 0, 0, 1, 0, 8'h00));

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
